// File: rtl/bus4_rr_arbiter_pkg.sv
// Shared constants and state encoding for the four-way round-robin bus arbiter.
package bus4_rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // 2'b11 is unused; the FSM falls back to IDLE if it ever appears.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN  = 2'b01,
        ST_GAP  = 2'b10
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/bus4_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: first requester after LastOwner (mod 4) wins.
module rr_pick4
    import bus4_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] Req,
    input  logic [SEL_W-1:0]   LastOwner,
    output logic               Valid,
    output logic [SEL_W-1:0]   Idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        Valid = 1'b0;
        Idx   = '0;
        cand  = '0;
        // Offset 4 wraps to LastOwner itself, so the previous owner is searched last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = LastOwner + SEL_W'(i);
            if (!Valid && Req[cand]) begin
                Valid = 1'b1;
                Idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus4_rr_arbiter.sv
// Round-robin owner FSM for a shared 4-input bus mux: one dead cycle between
// owners and an optional per-grant hold limit that preempts only under contention.
module bus4_rr_arbiter
    import bus4_rr_arbiter_pkg::*;
#(
    parameter int MaxHold = 8,
    parameter int CntBits = 4
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [NUM_REQ-1:0] Req,
    output logic [NUM_REQ-1:0] Grant,
    output logic [SEL_W-1:0]   Sel,
    output logic               Enable,
    output logic               Preempt,
    output logic               Busy
);

    localparam bit                 HOLD_LIMITED = (MaxHold != 0);
    localparam logic [CntBits-1:0] HOLD_LAST    = CntBits'(MaxHold - 1);

    arb_state_t         state, state_nx;
    logic [SEL_W-1:0]   owner, owner_nx;
    logic [SEL_W-1:0]   last_owner, last_nx;
    logic [CntBits-1:0] hold_cnt, hold_nx;
    logic               preempt_q, preempt_nx;
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic               others_req;

    rr_pick4 u_pick (
        .Req       (Req),
        .LastOwner (last_owner),
        .Valid     (pick_valid),
        .Idx       (pick_idx)
    );

    assign others_req = |(Req & ~onehot(owner));

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        last_nx    = last_owner;
        hold_nx    = hold_cnt;
        preempt_nx = 1'b0;
        case (state)
            ST_IDLE, ST_GAP: begin
                if (pick_valid) begin
                    state_nx = ST_OWN;
                    owner_nx = pick_idx;
                    last_nx  = pick_idx;
                    hold_nx  = '0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_OWN: begin
                // Release is checked first so a drop on the expiry cycle never preempts.
                if (!Req[owner]) begin
                    state_nx = ST_GAP;
                end else if (HOLD_LIMITED && hold_cnt == HOLD_LAST) begin
                    if (others_req) begin
                        state_nx   = ST_GAP;
                        preempt_nx = 1'b1;
                    end else begin
                        hold_nx = '0;
                    end
                end else if (hold_cnt != '1) begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= SEL_W'(NUM_REQ - 1);
            hold_cnt   <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
            hold_cnt   <= hold_nx;
            preempt_q  <= preempt_nx;
        end
    end

    // Outputs decode registered state only, so reset clears them asynchronously.
    assign Enable  = (state == ST_OWN);
    assign Grant   = Enable ? onehot(owner) : '0;
    assign Sel     = Enable ? owner : '0;
    assign Busy    = (state == ST_OWN) || (state == ST_GAP);
    assign Preempt = preempt_q;

endmodule
